// File: rtl/harmonic_mixer_if.sv
// Per-harmonic sample handshake between the mixer (master) and the
// sample-position / sine LUT responder (slave).
interface harmonic_mixer_if;
  logic        [7:0]  o_Harmonic;
  logic               o_Next_Sample;
  logic               i_Sample_Ready;
  logic signed [15:0] i_Sample_Value;
  logic               i_Freq_Too_High;
  logic        [7:0]  i_Level;

  modport master (
    output o_Harmonic, o_Next_Sample,
    input  i_Sample_Ready, i_Sample_Value, i_Freq_Too_High, i_Level
  );

  modport slave (
    input  o_Harmonic, o_Next_Sample,
    output i_Sample_Ready, i_Sample_Value, i_Freq_Too_High, i_Level
  );
endinterface

// File: rtl/harmonic_mixer.sv
// Per-frame harmonic sequencer: walks harmonics, scales and accumulates sine values,
// emits one mix word per frame. Define MIX_SATURATE_EN to clamp the output instead of wrapping.
module harmonic_mixer #(
  parameter int unsigned NUM_HARMONICS = 64,
  parameter int unsigned ACC_W         = 32,
  parameter int unsigned MIX_SHIFT     = 14,
  parameter int unsigned READ_DELAY    = 2
) (
  input  logic               i_Clock,
  input  logic               i_Reset_N,
  input  logic               i_Start,
  harmonic_mixer_if.master   hif,
  output logic signed [15:0] o_Mix,
  output logic               o_Mix_Valid,
  output logic               o_Busy,
  output logic               o_Overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_WAIT_DATA, S_ACCUM, S_ADVANCE, S_FINISH
  } state_t;

  localparam logic [7:0] LAST_HARM = 8'(NUM_HARMONICS - 1);

  state_t                   state_q, state_d;
  logic        [7:0]        harm_q, harm_d;
  logic                     ns_q, ns_d;
  logic        [7:0]        cnt_q, cnt_d;
  logic signed [24:0]       prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [15:0]       mix_q, mix_d;
  logic                     mv_q, mv_d;
  logic                     busy_q, busy_d;
  logic                     ov_q, ov_d;
  logic                     pend_q, pend_d;
  logic signed [15:0]       mix_out;

`ifdef MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_q >>> MIX_SHIFT;
    if (shifted > SAT_HI)      mix_out = 16'sh7FFF;
    else if (shifted < SAT_LO) mix_out = 16'sh8000;
    else                       mix_out = shifted[15:0];
  end
`else
  assign mix_out = 16'(acc_q >>> MIX_SHIFT);
`endif

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q <= S_IDLE;
      harm_q  <= '0;
      ns_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      mix_q   <= '0;
      mv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      harm_q  <= harm_d;
      ns_q    <= ns_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      mv_q    <= mv_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    harm_d  = harm_q;
    ns_d    = 1'b0;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    mix_d   = mix_q;
    mv_d    = 1'b0;
    busy_d  = busy_q;
    pend_d  = pend_q;
    // A start on the o_Mix_Valid cycle is treated like one arriving while busy.
    ov_d    = i_Start && (busy_q || mv_q);

    unique case (state_q)
      S_IDLE: begin
        if (i_Start && !mv_q) begin
          acc_d   = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (hif.i_Sample_Ready) begin
          cnt_d   = 8'(READ_DELAY);
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (hif.i_Freq_Too_High) begin
          pend_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          prod_d  = hif.i_Sample_Value * $signed({1'b0, hif.i_Level});
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d   = acc_q + $signed({{(ACC_W-25){prod_q[24]}}, prod_q});
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        ns_d = 1'b1;
        if (harm_q == LAST_HARM) begin
          harm_d  = '0;
          state_d = S_FINISH;
        end else begin
          harm_d  = harm_q + 8'd1;
          state_d = S_WAIT_RDY;
        end
      end
      S_FINISH: begin
        // Only the too-high exit still owes the responder its Next_Sample for this harmonic.
        harm_d  = '0;
        ns_d    = pend_q;
        pend_d  = 1'b0;
        mix_d   = mix_out;
        mv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hif.o_Harmonic    = harm_q;
  assign hif.o_Next_Sample = ns_q;
  assign o_Mix             = mix_q;
  assign o_Mix_Valid       = mv_q;
  assign o_Busy            = busy_q;
  assign o_Overrun         = ov_q;

endmodule

// File: tb/tb_harmonic_mixer.sv
// Directed bench for harmonic_mixer: 4 harmonics, MIX_SHIFT=9, READ_DELAY=2, with a
// behavioural LUT responder that also watches the handshake rules.
module tb_harmonic_mixer;
  localparam int NH = 4;
  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] mix;
  logic mv, busy, ov;

  harmonic_mixer_if hif();

  harmonic_mixer #(
    .NUM_HARMONICS(NH), .ACC_W(32), .MIX_SHIFT(9), .READ_DELAY(RD)
  ) dut (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Start(start), .hif(hif),
    .o_Mix(mix), .o_Mix_Valid(mv), .o_Busy(busy), .o_Overrun(ov)
  );

  always #5 clk = ~clk;

  int applied = 0;
  int miscompares = 0;

  logic signed [15:0] val_t [NH];
  logic        [7:0]  lvl_t [NH];
  logic               ft_t  [NH];
  int rdy_delay = 0;

  int ns_cnt = 0, mv_cnt = 0, ov_cnt = 0, viol = 0;
  logic [31:0] hist = '0;

  int base_ns, base_mv, base_ov, base_viol;
  bit busy_seen, timed_out;

  // Responder: ready rdy_delay clocks after each Next_Sample, value valid RD clocks after ready.
  initial begin : responder
    bit ready;
    int wcnt, age, idx;
    logic [7:0] prev;
    ready = 0; wcnt = 0; age = 0; prev = '0;
    hif.i_Sample_Ready = 0; hif.i_Sample_Value = '0;
    hif.i_Freq_Too_High = 0; hif.i_Level = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ready = 0; wcnt = rdy_delay; age = 0; prev = '0;
      end else begin
        if (hif.o_Next_Sample && !ready) viol++;
        if (hif.o_Harmonic != prev && !hif.o_Next_Sample) viol++;
        prev = hif.o_Harmonic;
        if (hif.o_Next_Sample) begin
          ns_cnt++;
          hist = {hist[23:0], hif.o_Harmonic};
        end
        if (mv) mv_cnt++;
        if (ov) ov_cnt++;
        if (hif.o_Next_Sample) begin
          ready = 0; wcnt = rdy_delay; age = 0;
        end else if (!ready) begin
          if (wcnt == 0) ready = 1; else wcnt--;
        end else if (age < RD) begin
          age++;
        end
      end
      idx = int'(hif.o_Harmonic) % NH;
      hif.i_Sample_Ready  = ready;
      hif.i_Level         = lvl_t[idx];
      hif.i_Freq_Too_High = ft_t[idx];
      hif.i_Sample_Value  = (ready && age >= RD) ? val_t[idx] : 16'sh5A5A;
    end
  end

  task automatic load(input logic signed [15:0] v0, v1, v2, v3,
                      input logic [7:0] l0, l1, l2, l3);
    val_t[0] = v0; val_t[1] = v1; val_t[2] = v2; val_t[3] = v3;
    lvl_t[0] = l0; lvl_t[1] = l1; lvl_t[2] = l2; lvl_t[3] = l3;
    for (int i = 0; i < NH; i++) ft_t[i] = 1'b0;
  endtask

  task automatic run_frame(input bit ov_mid, input bit ov_end);
    base_ns = ns_cnt; base_mv = mv_cnt; base_ov = ov_cnt; base_viol = viol;
    busy_seen = 0; timed_out = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    busy_seen = busy;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = (ov_mid && c == 8);
      if (mv) begin
        timed_out = 0;
        if (ov_end) start = 1;
        break;
      end
    end
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    applied++;
    if (timed_out !== 1'b0) begin
      miscompares++; $display("FAIL frame_timeout: no o_Mix_Valid within budget");
    end
  endtask

  task automatic check_frame(input string nm, input logic signed [15:0] exp_mix,
                             input int exp_ns);
    applied++;
    if (mix !== exp_mix) begin
      miscompares++; $display("FAIL %s_mix: got %0d want %0d", nm, mix, exp_mix);
    end
    applied++;
    if (ns_cnt - base_ns !== exp_ns) begin
      miscompares++; $display("FAIL %s_next_count: got %0d want %0d", nm, ns_cnt - base_ns, exp_ns);
    end
    applied++;
    if (mv_cnt - base_mv !== 1) begin
      miscompares++; $display("FAIL %s_valid_count: got %0d want 1", nm, mv_cnt - base_mv);
    end
    applied++;
    if (viol - base_viol !== 0) begin
      miscompares++; $display("FAIL %s_handshake: got %0d violations want 0", nm, viol - base_viol);
    end
    applied++;
    if (busy_seen !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL %s_busy: during %b after %b want 1/0", nm, busy_seen, busy);
    end
    applied++;
    if (hif.o_Harmonic !== 8'd0) begin
      miscompares++; $display("FAIL %s_harm_idle: got %0d want 0", nm, hif.o_Harmonic);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    applied++;
    if ({hif.o_Harmonic, hif.o_Next_Sample, mv, busy, ov} !== 12'd0) begin
      miscompares++;
      $display("FAIL %s_ctrl: harm=%0d ns=%b mv=%b busy=%b ov=%b want all 0",
               nm, hif.o_Harmonic, hif.o_Next_Sample, mv, busy, ov);
    end
    applied++;
    if (mix !== 16'sd0) begin
      miscompares++; $display("FAIL %s_mix: got %0d want 0", nm, mix);
    end
  endtask

  task automatic test_reset();
    load(16'sd0, 16'sd0, 16'sd0, 16'sd0, 8'd0, 8'd0, 8'd0, 8'd0);
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_basic();
    load(16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384, 8'd255, 8'd255, 8'd255, 8'd255);
    run_frame(0, 0);
    check_frame("basic", 16'sd32640, 4);
    applied++;
    if (hist !== {8'd1, 8'd2, 8'd3, 8'd0}) begin
      miscompares++; $display("FAIL basic_index_seq: got %h want 01020300", hist);
    end
  endtask

  task automatic test_level_zero();
    load(16'sd1000, -16'sd2000, 16'sd3000, -16'sd4000, 8'd0, 8'd10, 8'd20, 8'd30);
    run_frame(0, 0);
    check_frame("level_mix", -16'sd157, 4);
  endtask

  task automatic test_too_high();
    load(16'sd12000, -16'sd3000, 16'sd30000, 16'sd30000, 8'd100, 8'd200, 8'd255, 8'd255);
    ft_t[2] = 1'b1; ft_t[3] = 1'b1;
    run_frame(0, 0);
    check_frame("too_high", 16'sd1171, 3);
    applied++;
    if (hist[23:0] !== {8'd1, 8'd2, 8'd0}) begin
      miscompares++; $display("FAIL too_high_index_seq: got %h want 010200", hist[23:0]);
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] exp_pos, exp_neg;
`ifdef MIX_SATURATE_EN
    exp_pos = 16'sh7FFF; exp_neg = 16'sh8000;
`else
    exp_pos = -16'sd258; exp_neg = 16'sd256;
`endif
    load(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 8'd255, 8'd255, 8'd255, 8'd255);
    run_frame(0, 0);
    check_frame("sat_pos", exp_pos, 4);
    load(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 8'd255, 8'd255, 8'd255, 8'd255);
    run_frame(0, 0);
    check_frame("sat_neg", exp_neg, 4);
  endtask

  task automatic test_overrun();
    load(16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384, 8'd255, 8'd255, 8'd255, 8'd255);
    run_frame(1, 0);
    check_frame("overrun_mid", 16'sd32640, 4);
    applied++;
    if (ov_cnt - base_ov !== 1) begin
      miscompares++; $display("FAIL overrun_mid_pulses: got %0d want 1", ov_cnt - base_ov);
    end
    run_frame(0, 1);
    applied++;
    if (ov_cnt - base_ov !== 1) begin
      miscompares++; $display("FAIL overrun_end_pulses: got %0d want 1", ov_cnt - base_ov);
    end
    applied++;
    if (busy !== 1'b0 || mv_cnt - base_mv !== 1) begin
      miscompares++;
      $display("FAIL overrun_end_ignored: busy=%b frames=%0d want 0/1", busy, mv_cnt - base_mv);
    end
  endtask

  task automatic test_slow_ready();
    rdy_delay = 5;
    load(-16'sd16384, 16'sd8192, 16'sd100, -16'sd1, 8'd255, 8'd128, 8'd1, 8'd2);
    run_frame(0, 0);
    check_frame("slow_ready", -16'sd6112, 4);
    rdy_delay = 0;
  endtask

  task automatic test_mid_reset();
    load(16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384, 8'd255, 8'd255, 8'd255, 8'd255);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (12) @(negedge clk);
    applied++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_busy_before: got %b want 1", busy);
    end
    @(posedge clk); #2 rst_n = 0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run_frame(0, 0);
    check_frame("after_reset", 16'sd32640, 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_zero();
    test_too_high();
    test_saturation();
    test_overrun();
    test_slow_ready();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
